// File: rtl/quadra_pipe_if.sv
// Handshake, result and coefficient-write bundle for quadra_pipe.
// The master drives samples and table writes; the slave is the pipeline.
interface quadra_pipe_if #(
  parameter int X_W   = 24,
  parameter int SEG_W = 7,
  parameter int A_W   = 26,
  parameter int B_W   = 20,
  parameter int C_W   = 16,
  parameter int Y_W   = 24
);
  logic             in_valid;
  logic             in_ready;
  logic [X_W-1:0]   in_x;
  logic             in_rmode;
  logic             out_valid;
  logic             out_ready;
  logic [Y_W-1:0]   out_y;
  logic             out_sat;
  logic             cfg_we;
  logic [SEG_W-1:0] cfg_addr;
  logic [A_W-1:0]   cfg_a;
  logic [B_W-1:0]   cfg_b;
  logic [C_W-1:0]   cfg_c;

  modport master (
    output in_valid, in_x, in_rmode, out_ready,
    output cfg_we, cfg_addr, cfg_a, cfg_b, cfg_c,
    input  in_ready, out_valid, out_y, out_sat
  );

  modport slave (
    input  in_valid, in_x, in_rmode, out_ready,
    input  cfg_we, cfg_addr, cfg_a, cfg_b, cfg_c,
    output in_ready, out_valid, out_y, out_sat
  );
endinterface

// File: rtl/quadra_pipe.sv
// Segmented quadratic evaluator y = a + b*x2 + c*x2^2 (fixed point), 3-stage
// pipeline with a globally stalled valid/ready handshake and saturating rounding.
module quadra_pipe #(
  parameter int X_W     = 24,
  parameter int SEG_W   = 7,
  parameter int A_W     = 26,
  parameter int B_W     = 20,
  parameter int C_W     = 16,
  parameter int Y_ROUND = 2,
  parameter int Y_W     = 24
) (
  input logic          clk,
  input logic          rst_n,
  quadra_pipe_if.slave bus
);
  localparam int X2_W = X_W - SEG_W;
  localparam int AB_W = (A_W > B_W) ? A_W : B_W;
  localparam int S_W  = ((AB_W > C_W) ? AB_W : C_W) + 2;
  localparam int T_W  = A_W + B_W + C_W;

  localparam logic signed [S_W-1:0] Y_MAX = {{(S_W-Y_W+1){1'b0}}, {(Y_W-1){1'b1}}};
  localparam logic signed [S_W-1:0] Y_MIN = {{(S_W-Y_W+1){1'b1}}, {(Y_W-1){1'b0}}};

  logic                    en;
  logic [SEG_W-1:0]        x1;
  logic [X2_W-1:0]         x2_in;
  logic [X2_W-1:0]         sq_n;
  logic [2*X2_W-1:0]       x2_wide;
  logic [2*X2_W-1:0]       sq_full;
  logic [T_W-1:0]          tbl [2**SEG_W];

  logic                    v1;
  logic                    rm_1;
  logic [X2_W-1:0]         x2_1;
  logic [X2_W-1:0]         sq_1;
  logic signed [A_W-1:0]   a_1;
  logic signed [B_W-1:0]   b_1;
  logic signed [C_W-1:0]   c_1;

  logic signed [X2_W+B_W:0] p1;
  logic signed [X2_W+C_W:0] p2;
  logic signed [S_W-1:0]    t0_n;
  logic signed [S_W-1:0]    t1_n;
  logic signed [S_W-1:0]    t2_n;

  logic                    v2;
  logic                    rm_2;
  logic signed [S_W-1:0]   t0_2;
  logic signed [S_W-1:0]   t1_2;
  logic signed [S_W-1:0]   t2_2;

  logic signed [S_W-1:0]   sum;
  logic signed [S_W-1:0]   q;
  logic signed [S_W-1:0]   qr;
  logic                    inc;
  logic [Y_W-1:0]          y_n;
  logic                    sat_n;

  logic                    vo;
  logic [Y_W-1:0]          yo;
  logic                    so;

  // One enable for the whole pipe: any stall freezes every stage together.
  assign en            = !vo || bus.out_ready;
  assign bus.in_ready  = en;
  assign bus.out_valid = vo;
  assign bus.out_y     = yo;
  assign bus.out_sat   = so;

  always_comb begin
    x1      = bus.in_x[X_W-1:X2_W];
    x2_in   = bus.in_x[X2_W-1:0];
    x2_wide = {{X2_W{1'b0}}, x2_in};
    sq_full = x2_wide * x2_wide;
    sq_n    = X2_W'(sq_full >> X2_W);
  end

  // Table has no reset; nonblocking write gives read-before-write on a collision.
  always_ff @(posedge clk) begin
    if (bus.cfg_we) begin
      tbl[bus.cfg_addr] <= {bus.cfg_a, bus.cfg_b, bus.cfg_c};
    end
  end

  always_comb begin
    p1   = $signed({1'b0, x2_1}) * b_1;
    p2   = $signed({1'b0, sq_1}) * c_1;
    t0_n = S_W'(a_1);
    t1_n = S_W'(p1 >>> X2_W);
    t2_n = S_W'(p2 >>> X2_W);
  end

  always_comb begin
    sum = t0_2 + t1_2 + t2_2;
    q   = sum >>> Y_ROUND;
  end

  if (Y_ROUND > 0) begin : g_round
    localparam logic [Y_ROUND-1:0] HALF = Y_ROUND'(1) << (Y_ROUND - 1);
    logic [Y_ROUND-1:0] rem;
    always_comb begin
      rem = sum[Y_ROUND-1:0];
      inc = rm_2 && ((rem > HALF) || ((rem == HALF) && q[0]));
    end
  end else begin : g_no_round
    assign inc = 1'b0;
  end

  always_comb begin
    qr    = q + {{(S_W-1){1'b0}}, inc};
    y_n   = qr[Y_W-1:0];
    sat_n = 1'b0;
    if (qr > Y_MAX) begin
      y_n   = Y_MAX[Y_W-1:0];
      sat_n = 1'b1;
    end else if (qr < Y_MIN) begin
      y_n   = Y_MIN[Y_W-1:0];
      sat_n = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      rm_1 <= 1'b0;
      x2_1 <= '0;
      sq_1 <= '0;
      a_1  <= '0;
      b_1  <= '0;
      c_1  <= '0;
      v2   <= 1'b0;
      rm_2 <= 1'b0;
      t0_2 <= '0;
      t1_2 <= '0;
      t2_2 <= '0;
      vo   <= 1'b0;
      yo   <= '0;
      so   <= 1'b0;
    end else if (en) begin
      v1   <= bus.in_valid;
      rm_1 <= bus.in_rmode;
      x2_1 <= x2_in;
      sq_1 <= sq_n;
      {a_1, b_1, c_1} <= tbl[x1];
      v2   <= v1;
      rm_2 <= rm_1;
      t0_2 <= t0_n;
      t1_2 <= t1_n;
      t2_2 <= t2_n;
      vo   <= v2;
      yo   <= y_n;
      so   <= sat_n;
    end
  end
endmodule
